// File: rtl/keylock_pkg.sv
// Shared definitions for the keypad code checker.
// Holds the FSM state encoding, default timing constants and a digit-valid helper.
package keylock_pkg;

    typedef enum logic [1:0] {
        ST_LOCKED   = 2'd0,
        ST_CHECK    = 2'd1,
        ST_UNLOCKED = 2'd2,
        ST_LOCKOUT  = 2'd3
    } state_t;

    localparam int          DEF_CODE_LEN       = 4;
    localparam logic [15:0] DEF_CODE           = 16'h1234;
    localparam int          DEF_MAX_FAILS      = 3;
    localparam logic [31:0] DEF_LOCKOUT_CYCLES = 32'd120000000;
    localparam logic [31:0] DEF_IDLE_CYCLES    = 32'd60000000;
    localparam logic [3:0]  DIGIT_MAX          = 4'd9;

    function automatic logic is_digit(input logic [3:0] d);
        return (d != 4'd0) && (d <= DIGIT_MAX);
    endfunction

endpackage

// File: rtl/code_checker_if.sv
// Keypad-side bundle of the code checker.
// master: keypad scanner (drives button/bstate); slave: the checker (drives status).
interface code_checker_if;
    logic [3:0] button;
    logic       bstate;
    logic       unlocked;
    logic       lockout;
    logic [2:0] digit_count;
    logic       ok_pulse;
    logic       err_pulse;
    logic       code_changed;

    modport master (
        output button, bstate,
        input  unlocked, lockout, digit_count,
        input  ok_pulse, err_pulse, code_changed
    );

    modport slave (
        input  button, bstate,
        output unlocked, lockout, digit_count,
        output ok_pulse, err_pulse, code_changed
    );
endinterface

// File: rtl/key_event.sv
// Keypress event detector: falling edge of bstate carrying a digit 1..9.
// Ports: hwclk, reset, i_button, i_bstate -> o_valid (event strobe), o_digit.
module key_event
    import keylock_pkg::*;
(
    input  logic       hwclk,
    input  logic       reset,
    input  logic [3:0] i_button,
    input  logic       i_bstate,
    output logic       o_valid,
    output logic [3:0] o_digit
);

    logic r_bstate;
    logic w_fall;

    always_ff @(posedge hwclk) begin
        if (reset) r_bstate <= 1'b0;
        else       r_bstate <= i_bstate;
    end

    // button is held stable after the fall, so it is sampled in the same cycle
    assign w_fall  = r_bstate & ~i_bstate;
    assign o_valid = w_fall & is_digit(i_button);
    assign o_digit = i_button;

endmodule

// File: rtl/code_checker.sv
// Keypad code lock: collects CODE_LEN digits, checks them, locks out after
// MAX_FAILS misses and lets an unlocked user store a new code.
// Ports: hwclk, reset (sync, active high), bus (code_checker_if.slave).
module code_checker
    import keylock_pkg::*;
#(
    parameter int                    CODE_LEN       = DEF_CODE_LEN,
    parameter logic [4*CODE_LEN-1:0] DEFAULT_CODE   = DEF_CODE,
    parameter int                    MAX_FAILS      = DEF_MAX_FAILS,
    parameter logic [31:0]           LOCKOUT_CYCLES = DEF_LOCKOUT_CYCLES,
    parameter logic [31:0]           IDLE_CYCLES    = DEF_IDLE_CYCLES
) (
    input  logic          hwclk,
    input  logic          reset,
    code_checker_if.slave bus
);

    localparam int             CW        = 4 * CODE_LEN;
    localparam int             FW        = $clog2(MAX_FAILS + 1);
    localparam logic [FW-1:0]  FAIL_MAX  = FW'(MAX_FAILS);
    localparam logic [FW-1:0]  FAIL_LAST = FW'(MAX_FAILS - 1);
    localparam logic [2:0]     LAST_IDX  = 3'(CODE_LEN - 1);

    state_t          r_state;
    logic [CW-1:0]   r_code;
    logic [CW-1:0]   r_entry;
    logic [2:0]      r_count;
    logic [FW-1:0]   r_fails;
    logic [31:0]     r_timer;
    logic            r_unlocked;
    logic            r_lockout;
    logic            r_ok;
    logic            r_err;
    logic            r_chg;

    logic            w_valid;
    logic [3:0]      w_digit;
    logic [CW-1:0]   w_shift;
    logic            w_idle_done;
    logic            w_lock_done;

    key_event u_key_event (
        .hwclk    (hwclk),
        .reset    (reset),
        .i_button (bus.button),
        .i_bstate (bus.bstate),
        .o_valid  (w_valid),
        .o_digit  (w_digit)
    );

    // first-entered digit ends up in the MS nibble
    assign w_shift     = {r_entry[CW-5:0], w_digit};
    assign w_idle_done = (r_timer >= IDLE_CYCLES - 32'd1);
    assign w_lock_done = (r_timer >= LOCKOUT_CYCLES - 32'd1);

    always_ff @(posedge hwclk) begin
        if (reset) begin
            r_state    <= ST_LOCKED;
            r_code     <= DEFAULT_CODE;
            r_entry    <= '0;
            r_count    <= '0;
            r_fails    <= '0;
            r_timer    <= '0;
            r_unlocked <= 1'b0;
            r_lockout  <= 1'b0;
            r_ok       <= 1'b0;
            r_err      <= 1'b0;
            r_chg      <= 1'b0;
        end else begin
            r_ok    <= 1'b0;
            r_err   <= 1'b0;
            r_chg   <= 1'b0;
            r_timer <= r_timer + 32'd1;
            case (r_state)
                ST_LOCKED: begin
                    if (w_valid) begin
                        r_timer <= '0;
                        r_entry <= w_shift;
                        if (r_count == LAST_IDX) begin
                            r_count <= '0;
                            r_state <= ST_CHECK;
                        end else begin
                            r_count <= r_count + 3'd1;
                        end
                    end else if (w_idle_done) begin
                        r_timer <= '0;
                        r_count <= '0;
                    end
                end
                ST_CHECK: begin
                    // timer zeroed here so every exit state starts fresh
                    r_timer <= '0;
                    if (r_entry == r_code) begin
                        r_ok       <= 1'b1;
                        r_fails    <= '0;
                        r_state    <= ST_UNLOCKED;
                        r_unlocked <= 1'b1;
                    end else begin
                        r_err <= 1'b1;
                        if (r_fails >= FAIL_LAST) begin
                            r_fails   <= FAIL_MAX;
                            r_state   <= ST_LOCKOUT;
                            r_lockout <= 1'b1;
                        end else begin
                            r_fails <= r_fails + FW'(1);
                            r_state <= ST_LOCKED;
                        end
                    end
                end
                ST_UNLOCKED: begin
                    if (w_valid) begin
                        r_timer <= '0;
                        r_entry <= w_shift;
                        if (r_count == LAST_IDX) begin
                            r_code     <= w_shift;
                            r_chg      <= 1'b1;
                            r_count    <= '0;
                            r_state    <= ST_LOCKED;
                            r_unlocked <= 1'b0;
                        end else begin
                            r_count <= r_count + 3'd1;
                        end
                    end else if (w_idle_done) begin
                        r_timer    <= '0;
                        r_count    <= '0;
                        r_state    <= ST_LOCKED;
                        r_unlocked <= 1'b0;
                    end
                end
                ST_LOCKOUT: begin
                    if (w_lock_done) begin
                        r_timer   <= '0;
                        r_count   <= '0;
                        r_fails   <= '0;
                        r_state   <= ST_LOCKED;
                        r_lockout <= 1'b0;
                    end
                end
                default: r_state <= ST_LOCKED;
            endcase
        end
    end

    assign bus.unlocked     = r_unlocked;
    assign bus.lockout      = r_lockout;
    assign bus.digit_count  = r_count;
    assign bus.ok_pulse     = r_ok;
    assign bus.err_pulse    = r_err;
    assign bus.code_changed = r_chg;

endmodule

// File: doc/code_checker.md
CODE_CHECKER -- requirements
Module: code_checker

Interface
REQ-001 SHALL have parameter CODE_LEN, default 4, number of digits per code.
REQ-002 SHALL have parameter DEFAULT_CODE, default 16'h1234, power-up/reset code, one 4-bit digit per nibble, first-entered digit in the MS nibble.
REQ-003 SHALL have parameter MAX_FAILS, default 3, consecutive wrong codes before lockout.
REQ-004 SHALL have parameter LOCKOUT_CYCLES, default 32'd120000000, lockout duration (10 s at 12 MHz).
REQ-005 SHALL have parameter IDLE_CYCLES, default 32'd60000000, inactivity timeout (5 s) for partial entry and for the unlocked state.
REQ-006 Port hwclk, input, 1, 12 MHz system clock; all logic on posedge.
REQ-007 Port reset, input, 1, synchronous active-high reset.
REQ-008 Port button, input, 4, digit code from the keypad scanner, 1..9 valid; held stable while bstate high and after its fall.
REQ-009 Port bstate, input, 1, scanner key-press flag; its falling edge marks a completed keypress.
REQ-010 Port unlocked, output, 1, high while in UNLOCKED.
REQ-011 Port lockout, output, 1, high while in LOCKOUT.
REQ-012 Port digit_count, output, 3, digits collected in the current entry (0..CODE_LEN-1).
REQ-013 Port ok_pulse, output, 1, one-cycle pulse on correct code.
REQ-014 Port err_pulse, output, 1, one-cycle pulse on wrong code.
REQ-015 Port code_changed, output, 1, one-cycle pulse when a new code is stored.

Function
REQ-016 SHALL register bstate once; keypress event = registered bstate high AND current bstate low, sampling button in that same cycle.
REQ-017 SHALL ignore events whose button value is 0 or >9 (no count change, no timer reset).
REQ-018 SHALL implement states LOCKED, CHECK, UNLOCKED, LOCKOUT.
REQ-019 LOCKED: each valid event shifts the digit into the entry register and increments digit_count; the CODE_LEN-th digit moves to CHECK on the next cycle with digit_count back to 0.
REQ-020 CHECK lasts exactly one cycle: match -> UNLOCKED, ok_pulse, fail counter cleared; mismatch -> err_pulse, fail counter +1, then LOCKOUT if counter reaches MAX_FAILS, else LOCKED.
REQ-021 Events arriving during CHECK SHALL be discarded.
REQ-022 UNLOCKED: valid events collect a new code; on the CODE_LEN-th digit the stored code is replaced, code_changed pulses, state -> LOCKED.
REQ-023 An inactivity timer SHALL restart on every valid event and on state entry; reaching IDLE_CYCLES in LOCKED clears a partial entry (digit_count -> 0, no fail count), in UNLOCKED discards the partial new code and returns to LOCKED.
REQ-024 LOCKOUT: all events ignored; after LOCKOUT_CYCLES -> LOCKED, fail counter cleared, digit_count 0.
REQ-025 Fail counter SHALL saturate at MAX_FAILS and never wrap.
REQ-026 Pulses SHALL never assert simultaneously; outputs are registered.

Reset
REQ-027 On reset: state LOCKED, stored code = DEFAULT_CODE, entry cleared, fail counter 0, timers 0, bstate register 0, all outputs 0.
REQ-028 Reset asserted mid-entry, during lockout, or while unlocked SHALL take effect next edge and discard any changed code.

Structure
REQ-029 State encoding and default timing constants SHALL live in shared package keylock_pkg.
REQ-030 The falling-edge/digit-valid detection SHALL be a sub-module key_event.

Verification
REQ-031 Reset, press/release 1,2,3,4 -> ok_pulse one cycle after 4th release, unlocked=1.
REQ-032 Enter 1,2,3,5 three times (IDLE/LOCKOUT reduced to 1000/500) -> err_pulse x3, lockout=1 for 500 cycles, then lockout=0, digit_count=0.
REQ-033 Unlock, enter 9,8,7,6 -> code_changed, unlocked=0; 1,2,3,4 -> err_pulse; 9,8,7,6 -> ok_pulse.
REQ-034 Enter 1,2 then idle 1000 cycles -> digit_count=0; then 1,2,3,4 -> ok_pulse.
REQ-035 Hold bstate high 50 cycles with button=5 -> no count change until fall, then digit_count=1; button=0 release -> ignored.
REQ-036 Assert reset after changing code to 9876 -> 1,2,3,4 unlocks.
